// File: rtl/shift_load_seq_pkg.sv
// Shared types and helpers for the shift/load sequencer.
// Opcodes, FSM state encoding and the shift-count clamp.
package shift_load_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_CLEAR = 3'd1,
    OP_LOAD  = 3'd2,
    OP_SHL   = 3'd3,
    OP_SHR   = 3'd4,
    OP_ROL   = 3'd5,
    OP_ROR   = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // A register can never usefully shift more than its own width.
  function automatic int unsigned eff_amt(input int unsigned amt, input int unsigned width);
    return (amt > width) ? width : amt;
  endfunction

  function automatic logic is_shift_op(input op_e op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROL) || (op == OP_ROR);
  endfunction

endpackage

// File: rtl/shift_load_seq_if.sv
// Command and result bundle between a command source and shift_load_seq.
// The master issues commands; the slave (the sequencer) returns the register view.
interface shift_load_seq_if #(
  parameter int WIDTH = 16,
  parameter int AMT_W = $clog2(WIDTH + 1)
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [AMT_W-1:0] cmd_amt;
  logic [WIDTH-1:0] load_data;
  logic             ser_in;
  logic [WIDTH-1:0] q;
  logic             ser_out;
  logic             busy;
  logic             done;

  modport master (
    output cmd_valid, cmd_op, cmd_amt, load_data, ser_in,
    input  cmd_ready, q, ser_out, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_amt, load_data, ser_in,
    output cmd_ready, q, ser_out, busy, done
  );

endinterface

// File: rtl/shift_load_seq_step.sv
// Single-step combinational shift/rotate unit.
// Non-shift opcodes pass the word through and report a zero exit bit.
module shift_step
  import shift_load_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] q,
  input  op_e              op,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q_next,
  output logic             bit_out
);

  always_comb begin
    q_next  = q;
    bit_out = 1'b0;
    case (op)
      OP_SHL: begin
        q_next  = {q[WIDTH-2:0], ser_in};
        bit_out = q[WIDTH-1];
      end
      OP_SHR: begin
        q_next  = {ser_in, q[WIDTH-1:1]};
        bit_out = q[0];
      end
      OP_ROL: begin
        q_next  = {q[WIDTH-2:0], q[WIDTH-1]};
        bit_out = q[WIDTH-1];
      end
      OP_ROR: begin
        q_next  = {q[0], q[WIDTH-1:1]};
        bit_out = q[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/shift_load_seq.sv
// Registered shift/load register; multi-bit shifts and rotates run one bit per cycle.
//   state    | meaning
//   ST_IDLE  | ready for a command; CLEAR/LOAD/NOP/zero-count shifts finish here
//   ST_SHIFT | stepping the latched op once per edge until the down-counter hits 1
module shift_load_seq
  import shift_load_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AMT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  shift_load_seq_if.slave    bus
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             ser_out_q, ser_out_d;
  logic             done_q, done_d;

  op_e              cmd_op;
  logic [AMT_W-1:0] amt_eff;
  logic [WIDTH-1:0] step_q;
  logic             step_bit;

  assign cmd_op  = op_e'(bus.cmd_op);
  assign amt_eff = AMT_W'(eff_amt(32'(bus.cmd_amt), WIDTH));

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .q       (q_q),
    .op      (op_q),
    .ser_in  (bus.ser_in),
    .q_next  (step_q),
    .bit_out (step_bit)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    q_d       = q_q;
    ser_out_d = ser_out_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          case (cmd_op)
            OP_CLEAR: begin
              q_d    = '0;
              done_d = 1'b1;
            end
            OP_LOAD: begin
              q_d    = bus.load_data;
              done_d = 1'b1;
            end
            OP_SHL, OP_SHR, OP_ROL, OP_ROR: begin
              if (amt_eff == '0) begin
                done_d = 1'b1;
              end else begin
                state_d = ST_SHIFT;
                op_d    = cmd_op;
                cnt_d   = amt_eff;
              end
            end
            default: done_d = 1'b1;
          endcase
        end
      end
      ST_SHIFT: begin
        q_d       = step_q;
        ser_out_d = step_bit;
        cnt_d     = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_NOP;
      cnt_q     <= '0;
      q_q       <= '0;
      ser_out_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      q_q       <= q_d;
      ser_out_q <= ser_out_d;
      done_q    <= done_d;
    end
  end

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.busy      = (state_q == ST_SHIFT);
  assign bus.q         = q_q;
  assign bus.ser_out   = ser_out_q;
  assign bus.done      = done_q;

  // A SHIFT state always carries a live step op and a non-zero count.
  a_shift_cnt : assert property (@(posedge clk) disable iff (rst)
    (state_q == ST_SHIFT) |-> (cnt_q != '0 && is_shift_op(op_q)));
  a_done_ready : assert property (@(posedge clk) disable iff (rst)
    done_q |-> (state_q == ST_IDLE));

endmodule

// File: tb/tb_shift_load_seq.sv
// Directed bench for shift_load_seq (WIDTH=8) with a per-cycle reference model.
// The model tracks the register as a number and a remaining-step count.
module tb_shift_load_seq;
  import shift_load_pkg::*;

  localparam int W  = 8;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  shift_load_seq_if #(.WIDTH(W), .AMT_W(AW)) bus ();

  shift_load_seq #(.WIDTH(W), .AMT_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the register value, last exit bit and steps still owed.
  logic [W-1:0] m_q    = '0;
  logic         m_ser  = 1'b0;
  logic         m_done = 1'b0;
  int           m_left = 0;
  int           m_op   = 0;
  int           m_n;
  logic [W-1:0] m_old;

  always @(posedge clk) begin
    m_old = m_q;
    if (rst) begin
      m_q = '0; m_ser = 1'b0; m_done = 1'b0; m_left = 0;
    end else if (m_left > 0) begin
      case (m_op)
        3: begin m_q = (m_old << 1) | W'(bus.ser_in);             m_ser = m_old[W-1]; end
        4: begin m_q = (m_old >> 1) | (W'(bus.ser_in) << (W-1));  m_ser = m_old[0];   end
        5: begin m_q = (m_old << 1) | (m_old >> (W-1));           m_ser = m_old[W-1]; end
        default: begin m_q = (m_old >> 1) | (m_old << (W-1));     m_ser = m_old[0];   end
      endcase
      m_left = m_left - 1;
      m_done = (m_left == 0);
    end else begin
      m_done = 1'b0;
      if (bus.cmd_valid) begin
        m_n = (int'(bus.cmd_amt) < W) ? int'(bus.cmd_amt) : W;
        case (int'(bus.cmd_op))
          1: begin m_q = '0;            m_done = 1'b1; end
          2: begin m_q = bus.load_data; m_done = 1'b1; end
          3, 4, 5, 6: begin
            if (m_n == 0) m_done = 1'b1;
            else begin m_left = m_n; m_op = int'(bus.cmd_op); end
          end
          default: m_done = 1'b1;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    check("cyc_q",       32'(bus.q),         32'(m_q));
    check("cyc_ser_out", 32'(bus.ser_out),   32'(m_ser));
    check("cyc_done",    32'(bus.done),      32'(m_done));
    check("cyc_busy",    32'(bus.busy),      32'(m_left > 0));
    check("cyc_ready",   32'(bus.cmd_ready), 32'(m_left == 0));
  end

  task automatic idle_inputs();
    bus.cmd_valid = 1'b0; bus.cmd_op = 3'd0; bus.cmd_amt = '0; bus.load_data = '0;
  endtask

  // Present one command for a single edge; returns at the negedge after acceptance.
  task automatic send(input logic [2:0] op, input logic [AW-1:0] amt,
                      input logic [W-1:0] data, input logic sin);
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_amt = amt;
    bus.load_data = data; bus.ser_in = sin;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [W-1:0] eq, input logic eser,
                            input logic ebusy, input logic edone);
    check({tag, "_q"},       32'(bus.q),       32'(eq));
    check({tag, "_ser_out"}, 32'(bus.ser_out), 32'(eser));
    check({tag, "_busy"},    32'(bus.busy),    32'(ebusy));
    check({tag, "_done"},    32'(bus.done),    32'(edone));
  endtask

  initial begin
    bus.ser_in = 1'b0;
    // Reset with random inputs for two edges.
    for (int i = 0; i < 2; i++) begin
      bus.cmd_valid = 1'($urandom); bus.cmd_op = 3'($urandom); bus.cmd_amt = AW'($urandom);
      bus.load_data = W'($urandom); bus.ser_in = 1'($urandom);
      @(negedge clk);
    end
    expect_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    check("reset_ready", 32'(bus.cmd_ready), 32'd1);
    rst = 1'b0;
    idle_inputs();
    bus.ser_in = 1'b0;
    @(negedge clk);

    // LOAD then CLEAR on consecutive edges.
    bus.cmd_valid = 1'b1; bus.cmd_op = 3'd2; bus.load_data = 8'hA5;
    @(negedge clk);
    expect_out("load_a5", 8'hA5, 1'b0, 1'b0, 1'b1);
    bus.cmd_op = 3'd1;
    @(negedge clk);
    expect_out("clear", 8'h00, 1'b0, 1'b0, 1'b1);
    idle_inputs();
    @(negedge clk);
    check("clear_done_drop", 32'(bus.done), 32'd0);

    // SHL by 3 with ser_in=1.
    send(3'd2, '0, 8'hA5, 1'b0);
    send(3'd3, 4'd3, 8'h00, 1'b1);
    expect_out("shl_acc", 8'hA5, 1'b0, 1'b1, 1'b0);
    @(negedge clk); expect_out("shl_s1", 8'h4B, 1'b1, 1'b1, 1'b0);
    @(negedge clk); expect_out("shl_s2", 8'h97, 1'b0, 1'b1, 1'b0);
    @(negedge clk); expect_out("shl_s3", 8'h2F, 1'b1, 1'b0, 1'b1);

    // LOAD keeps the previous exit bit; ROR by 4 ignores a LOAD issued while busy.
    send(3'd2, '0, 8'hA5, 1'b0);
    expect_out("load_keep_ser", 8'hA5, 1'b1, 1'b0, 1'b1);
    send(3'd6, 4'd4, 8'h00, 1'b0);
    bus.cmd_valid = 1'b1; bus.cmd_op = 3'd2; bus.load_data = 8'hFF;
    @(negedge clk); expect_out("ror_s1", 8'hD2, 1'b1, 1'b1, 1'b0);
    @(negedge clk); expect_out("ror_s2", 8'h69, 1'b0, 1'b1, 1'b0);
    idle_inputs();
    @(negedge clk); expect_out("ror_s3", 8'hB4, 1'b1, 1'b1, 1'b0);
    @(negedge clk); expect_out("ror_s4", 8'h5A, 1'b0, 1'b0, 1'b1);
    @(negedge clk); expect_out("ror_after", 8'h5A, 1'b0, 1'b0, 1'b0);

    // Count clamped to the width.
    send(3'd2, '0, 8'hFF, 1'b0);
    send(3'd4, 4'd12, 8'h00, 1'b0);
    repeat (7) @(negedge clk);
    expect_out("shr_s7", 8'h01, 1'b1, 1'b1, 1'b0);
    @(negedge clk); expect_out("shr_s8", 8'h00, 1'b1, 1'b0, 1'b1);

    // Zero count, ROL, NOP and reserved opcode.
    send(3'd3, 4'd0, 8'h00, 1'b1);
    expect_out("shl_zero", 8'h00, 1'b1, 1'b0, 1'b1);
    send(3'd2, '0, 8'h81, 1'b0);
    send(3'd5, 4'd1, 8'h00, 1'b0);
    @(negedge clk); expect_out("rol_1", 8'h03, 1'b1, 1'b0, 1'b1);
    send(3'd0, 4'd5, 8'hEE, 1'b0);
    expect_out("nop", 8'h03, 1'b1, 1'b0, 1'b1);
    send(3'd7, 4'd5, 8'hEE, 1'b0);
    expect_out("rsvd", 8'h03, 1'b1, 1'b0, 1'b1);

    // Reset at the second step edge of a 5-step SHL.
    send(3'd2, '0, 8'h81, 1'b0);
    send(3'd3, 4'd5, 8'h00, 1'b0);
    @(negedge clk); expect_out("rst_mid_s1", 8'h02, 1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    expect_out("rst_mid", 8'h00, 1'b0, 1'b0, 1'b0);
    check("rst_mid_ready", 32'(bus.cmd_ready), 32'd1);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rst_mid_no_done", 32'(bus.done), 32'd0);
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
